// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic leaf blocks.
package arith_pkg;

   localparam int ADDER_WIDTH_DEFAULT = 4;

endpackage : arith_pkg

// File: rtl/full_adder_bit.sv
// One-bit full adder; the ripple chain in f_adder is built from these.
module full_adder_bit (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic sum,
   output logic co
);

   assign sum = x ^ y ^ ci;
   assign co  = (x & y) | (x & ci) | (y & ci);

endmodule : full_adder_bit

// File: rtl/f_adder.sv
// Registered unsigned ripple-carry adder: {c_out, s} is a + b, one cycle after the operands.
module f_adder
   import arith_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
   output logic             c_out
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_bit u_bit (
         .x   (a[i]),
         .y   (b[i]),
         .ci  (carry[i]),
         .sum (sum[i]),
         .co  (carry[i+1])
      );
   end

   // Sum and carry share one register so they always describe the same operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s     <= '0;
         c_out <= 1'b0;
      end else begin
         s     <= sum;
         c_out <= carry[WIDTH];
      end
   end

endmodule : f_adder

// File: tb/tb_f_adder.sv
// Scoreboard bench for f_adder at WIDTH=4 (directed + exhaustive) and WIDTH=8 (random).
module tb_f_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] a4, b4, s4;
   logic       c4;
   logic [7:0] a8, b8, s8;
   logic       c8;

   int checks   = 0;
   int failures = 0;

   logic [4:0] q4[$];
   logic [8:0] q8[$];

   always #5 clk = ~clk;

   f_adder #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a4),
      .b     (b4),
      .s     (s4),
      .c_out (c4)
   );

   f_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a8),
      .b     (b8),
      .s     (s8),
      .c_out (c8)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: exact unsigned sum of the operands, widened by one bit.
   task automatic push_expected(input logic [3:0] x, input logic [3:0] y,
                                input logic [7:0] u, input logic [7:0] v);
      int sum4, sum8;
      sum4 = int'(x) + int'(y);
      sum8 = int'(u) + int'(v);
      q4.push_back(sum4[4:0]);
      q8.push_back(sum8[8:0]);
   endtask

   task automatic issue(input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] u, input logic [7:0] v);
      @(negedge clk);
      a4 = x;
      b4 = y;
      a8 = u;
      b8 = v;
      push_expected(x, y, u, v);
   endtask

   // Monitor: the DUT presents a new result after every rising edge out of reset.
   initial begin
      logic [4:0] e4;
      logic [8:0] e8;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && q4.size() > 0) begin
            e4 = q4.pop_front();
            check("w4_sum", 32'({c4, s4}), 32'(e4));
         end
         if (rst_n && q8.size() > 0) begin
            e8 = q8.pop_front();
            check("w8_sum", 32'({c8, s8}), 32'(e8));
         end
      end
   end

   initial begin
      logic [7:0] p;
      rst_n = 1'b0;
      a4 = 4'd7;
      b4 = 4'd3;
      a8 = 8'd200;
      b8 = 8'd100;

      #1;
      check("rst_async_s4", 32'(s4), 32'd0);
      check("rst_async_c4", 32'(c4), 32'd0);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("rst_hold_s4", 32'(s4), 32'd0);
         check("rst_hold_c4", 32'(c4), 32'd0);
         check("rst_hold_w8", 32'({c8, s8}), 32'd0);
      end

      @(negedge clk);
      rst_n = 1'b1;
      push_expected(4'd7, 4'd3, 8'd200, 8'd100);

      issue(4'd0,  4'd0, 8'd0,   8'd0);
      issue(4'd1,  4'd1, 8'd255, 8'd255);
      issue(4'd15, 4'd15, 8'd255, 8'd1);
      issue(4'd15, 4'd1, 8'd128, 8'd128);
      issue(4'd3,  4'd4, 8'($urandom), 8'($urandom));
      issue(4'd8,  4'd8, 8'($urandom), 8'($urandom));
      issue(4'd9,  4'd6, 8'($urandom), 8'($urandom));
      issue(4'd9,  4'd6, 8'd7, 8'd9);

      // Reset between edges while s4 holds 14.
      issue(4'd15, 4'd15, 8'd255, 8'd255);
      @(posedge clk);
      #3;
      check("pre_midrst_s4", 32'(s4), 32'd14);
      rst_n = 1'b0;
      #1;
      check("midrst_s4", 32'(s4), 32'd0);
      check("midrst_c4", 32'(c4), 32'd0);
      check("midrst_w8", 32'({c8, s8}), 32'd0);
      @(posedge clk);
      #1;
      check("midrst_hold_w4", 32'({c4, s4}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 256; i++) begin
         p = 8'(i);
         issue(p[7:4], p[3:0], 8'($urandom), 8'($urandom));
      end

      for (int n = 0; n < 10 && (q4.size() > 0 || q8.size() > 0); n++) @(negedge clk);
      if (q4.size() > 0 || q8.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q4.size() + q8.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_f_adder
